// File: rtl/clkdiv_pkg.sv
// Shared constants, controller states and sizing helper for the clock divider bank.
package clkdiv_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
    localparam int unsigned FREQ_W         = 32;
    localparam int unsigned DIVISOR_W      = 33;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } ctrl_state_e;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider: 32-bit dividend, 33-bit divisor, one quotient bit per clock.
module serial_divider
    import clkdiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [FREQ_W-1:0]    dividend,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [FREQ_W-1:0]    quotient,
    output logic                 done_c
);

    localparam int unsigned STEP_W = $clog2(FREQ_W + 1);

    logic [STEP_W-1:0]    steps;
    logic [DIVISOR_W-1:0] den;
    logic [DIVISOR_W-1:0] rem;
    logic [FREQ_W-1:0]    acc;
    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W:0]   diff;

    // acc shifts the dividend out at the top while quotient bits enter at the bottom
    always_comb begin
        trial = {rem, acc[FREQ_W-1]};
        diff  = trial - {1'b0, den};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            steps <= '0;
            den   <= '0;
            rem   <= '0;
            acc   <= '0;
        end else if (start) begin
            steps <= STEP_W'(FREQ_W);
            den   <= divisor;
            rem   <= '0;
            acc   <= dividend;
        end else if (steps != '0) begin
            steps <= steps - STEP_W'(1);
            if (!diff[DIVISOR_W]) begin
                rem <= diff[DIVISOR_W-1:0];
                acc <= {acc[FREQ_W-2:0], 1'b1};
            end else begin
                rem <= trial[DIVISOR_W-1:0];
                acc <= {acc[FREQ_W-2:0], 1'b0};
            end
        end
    end

    assign quotient = acc;
    // High during the final iteration; quotient is complete after this edge.
    assign done_c   = (steps == STEP_W'(1));

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock generator; frequency requests are converted
// to half-period counts by one shared serial divider.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter  int unsigned CLK_HZ   = DEFAULT_CLK_HZ,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned CNT_W    = 32,
    localparam int unsigned CHAN_W   = chan_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [FREQ_W-1:0]   cfg_freq,
    output logic                cfg_err,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam int unsigned         CHAN_SPAN = 1 << CHAN_W;
    localparam logic [CHAN_SPAN-1:0] CHAN_OK  = {CHAN_SPAN{1'b1}} >> (CHAN_SPAN - CHANNELS);
    localparam logic [FREQ_W-1:0]   FREQ_MAX  = FREQ_W'(CLK_HZ / 2);
    localparam logic [FREQ_W-1:0]   DIVIDEND  = FREQ_W'(CLK_HZ);

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic              accept_c;
    logic              in_range_c;
    logic              div_start_c;
    logic              div_done_c;
    logic              commit_c;
    logic [CHAN_W-1:0] chan_q;
    logic [FREQ_W-1:0] quotient;
    logic [CNT_W-1:0]  half;

    assign accept_c    = cfg_valid && cfg_ready;
    assign in_range_c  = (cfg_freq != '0) && (cfg_freq <= FREQ_MAX) && CHAN_OK[cfg_chan];
    assign div_start_c = accept_c && in_range_c;
    assign commit_c    = (state == COMMIT);
    assign half        = CNT_W'(quotient);

    serial_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (DIVIDEND),
        .divisor  ({cfg_freq, 1'b0}),
        .quotient (quotient),
        .done_c   (div_done_c)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = in_range_c ? DIV : ERR;
            DIV:     if (div_done_c) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            chan_q    <= '0;
        end else begin
            state     <= state_next;
            cfg_ready <= (state_next == IDLE);
            cfg_err   <= (state == ERR);
            if (div_start_c) chan_q <= cfg_chan;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic             configured;
        logic             clk_q;
        logic             tick_q;
        logic             commit_here;
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] cnt;

        assign commit_here = commit_c && (chan_q == CHAN_W'(g));

        // An idle channel takes a new rate immediately; a running one defers it to its next toggle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                configured <= 1'b0;
                active     <= '0;
                shadow     <= '0;
                cnt        <= '0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else if (commit_here && (!configured || !en[g])) begin
                configured <= 1'b1;
                active     <= half;
                shadow     <= half;
                cnt        <= '0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else if (!configured || !en[g]) begin
                cnt        <= '0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                if (commit_here) shadow <= half;
                if (cnt == active - CNT_W'(1)) begin
                    cnt    <= '0;
                    clk_q  <= !clk_q;
                    tick_q <= !clk_q;
                    active <= shadow;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: handshake latency, half-period
// scoreboard, rate changes, rejects, enable gating and reset abort.
module tb_clock_divider_bank;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [31:0] cfg_freq;
    logic        cfg_err;
    logic [3:0]  en;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int obs_q[$];

    clock_divider_bank dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_freq  (cfg_freq),
        .cfg_err   (cfg_err),
        .en        (en),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns cycles cfg_ready stayed low and whether cfg_err pulsed.
    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] f,
                             output int lat, output bit err);
        cfg_chan  = ch;
        cfg_freq  = f;
        cfg_valid = 1'b1;
        lat = 0;
        err = 1'b0;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_err) err = 1'b1;
            if (cfg_ready) break;
            lat++;
        end
    endtask

    // Records cycles between clk_out[ch] transitions into obs_q; -1 marks a timeout.
    task automatic watch(input int ch, input int n, output int tick_bad);
        logic prev;
        int   run;
        int   got;
        prev = clk_out[ch];
        run = 0;
        got = 0;
        tick_bad = 0;
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            @(negedge clk);
            run++;
            if (tick[ch] !== (clk_out[ch] && !prev)) tick_bad++;
            if (clk_out[ch] !== prev) begin
                obs_q.push_back(run);
                run = 0;
                got++;
                prev = clk_out[ch];
            end
        end
        while (got < n) begin
            obs_q.push_back(-1);
            got++;
        end
    endtask

    task automatic sync_rise(input int ch);
        logic prev;
        prev = clk_out[ch];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clk_out[ch] && !prev) break;
            prev = clk_out[ch];
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (clk_out !== 4'b0)  begin n_fail++; $display("FAIL reset_clk_out: got %b expected 0000", clk_out); end
        n_tests++; if (tick !== 4'b0)     begin n_fail++; $display("FAIL reset_tick: got %b expected 0000", tick); end
        n_tests++; if (cfg_err !== 1'b0)  begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_25m();
        int lat; bit err; int tb; int e; int o;
        en = 4'b0001;
        cfg_write(2'd0, 32'd25_000_000, lat, err);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL basic_ready_low: got %0d expected 33", lat); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
        repeat (6) exp_q.push_back(2);
        watch(0, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL basic_half: got %0d expected %0d", o, e); end
        end
        n_tests++; if (tb !== 0) begin n_fail++; $display("FAIL basic_tick: got %0d bad ticks expected 0", tb); end
    endtask

    task automatic test_ch1_fast();
        int lat; bit err; int tb; int e; int o;
        en = 4'b0011;
        cfg_write(2'd1, 32'd50_000_000, lat, err);
        n_tests++; if (lat !== 33 || err !== 1'b0) begin n_fail++; $display("FAIL ch1_50m_cfg: got lat %0d err %b expected 33 0", lat, err); end
        repeat (6) exp_q.push_back(1);
        watch(1, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL ch1_50m_half: got %0d expected %0d", o, e); end
        end
        n_tests++; if (tb !== 0) begin n_fail++; $display("FAIL ch1_50m_tick: got %0d bad ticks expected 0", tb); end
        cfg_write(2'd1, 32'd30_000_000, lat, err);
        n_tests++; if (lat !== 33 || err !== 1'b0) begin n_fail++; $display("FAIL ch1_30m_cfg: got lat %0d err %b expected 33 0", lat, err); end
        repeat (4) exp_q.push_back(1);
        watch(1, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL ch1_30m_half: got %0d expected %0d", o, e); end
        end
    endtask

    // Commit lands on a toggle edge: one more old-rate half, then the new rate.
    task automatic test_rate_change();
        int lat; bit err; int tb; int e; int o;
        sync_rise(0);
        cfg_write(2'd0, 32'd10_000_000, lat, err);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL rate_ready_low: got %0d expected 33", lat); end
        exp_q.push_back(2);
        repeat (3) exp_q.push_back(5);
        watch(0, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rate_half: got %0d expected %0d", o, e); end
        end
        n_tests++; if (tb !== 0) begin n_fail++; $display("FAIL rate_tick: got %0d bad ticks expected 0", tb); end
    endtask

    task automatic test_reject();
        int lat; bit err; int tb; int o;
        logic [31:0] bad_f[2];
        bad_f[0] = 32'd0;
        bad_f[1] = 32'd60_000_000;
        for (int i = 0; i < 2; i++) begin
            cfg_write(2'd0, bad_f[i], lat, err);
            n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL reject_ready_low f=%0d: got %0d expected 1", bad_f[i], lat); end
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL reject_err f=%0d: got %b expected 1", bad_f[i], err); end
            @(negedge clk);
            n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reject_err_width f=%0d: got %b expected 0", bad_f[i], cfg_err); end
        end
        watch(0, 3, tb);
        o = obs_q.pop_front();
        n_tests++; if (o < 1 || o > 5) begin n_fail++; $display("FAIL reject_partial: got %0d expected 1..5", o); end
        repeat (2) exp_q.push_back(5);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++; if (o !== exp_q[0]) begin n_fail++; $display("FAIL reject_unchanged: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_enable();
        int tb; int e; int o; bit held;
        sync_rise(0);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        n_tests++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin n_fail++; $display("FAIL en_off: got clk %b tick %b expected 0 0", clk_out[0], tick[0]); end
        held = 1'b1;
        repeat (6) begin @(negedge clk); if (clk_out[0] !== 1'b0) held = 1'b0; end
        n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL en_off_hold: got %b expected 1", held); end
        en[0] = 1'b1;
        repeat (3) exp_q.push_back(5);
        watch(0, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL en_resume_half: got %0d expected %0d", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit err; int tb; int e; int o;
        cfg_write(2'd2, 32'd5_000_000, lat, err);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_ch2_cfg: got %0d expected 33", lat); end
        cfg_write(2'd3, 32'd12_345_678, lat, err);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_ch3_cfg: got %0d expected 33", lat); end
        repeat (3) @(negedge clk);
        n_tests++; if (clk_out[3:2] !== 2'b00) begin n_fail++; $display("FAIL b2b_disabled: got %b expected 00", clk_out[3:2]); end
        en[3] = 1'b1;
        repeat (4) exp_q.push_back(4);
        watch(3, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_ch3_half: got %0d expected %0d", o, e); end
        end
        en[2] = 1'b1;
        repeat (3) exp_q.push_back(10);
        watch(2, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_ch2_half: got %0d expected %0d", o, e); end
        end
        n_tests++; if (tb !== 0) begin n_fail++; $display("FAIL b2b_tick: got %0d bad ticks expected 0", tb); end
    endtask

    task automatic test_reset_mid_div();
        int lat; bit err; int tb; int e; int o; bit held;
        cfg_chan  = 2'd2;
        cfg_freq  = 32'd1_000_000;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++; if (clk_out !== 4'b0 || tick !== 4'b0) begin n_fail++; $display("FAIL rst_async_out: got clk %b tick %b expected 0000 0000", clk_out, tick); end
        n_tests++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_cfg: got ready %b err %b expected 1 0", cfg_ready, cfg_err); end
        @(negedge clk);
        rst = 1'b1;
        held = 1'b1;
        repeat (20) begin @(negedge clk); if (clk_out !== 4'b0) held = 1'b0; end
        n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL rst_unconfigured: got %b expected 1", held); end
        cfg_write(2'd0, 32'd25_000_000, lat, err);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL rst_recfg: got %0d expected 33", lat); end
        repeat (2) exp_q.push_back(2);
        watch(0, exp_q.size(), tb);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rst_recfg_half: got %0d expected %0d", o, e); end
        end
        n_tests++; if (clk_out[3:1] !== 3'b000) begin n_fail++; $display("FAIL rst_others_low: got %b expected 000", clk_out[3:1]); end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_freq  = '0;
        en        = '0;
        test_reset();
        test_basic_25m();
        test_ch1_fast();
        test_rate_change();
        test_reject();
        test_enable();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock-enable/clock generator that replaces single fixed-frequency dividers. Each of CHANNELS outputs runs at a requested frequency in Hz. The frequency is converted to a half-period count by one shared serial divider, so there is no combinational `/` in the datapath. New rates take effect glitch-free at the channel's next toggle. The block sits beside the CPU top level and drives slow clocks and strobes for the display scan, key debounce and UART timing.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz; must be < 2^CNT_W.
- CHANNELS, 4, number of independent outputs (≥1).
- CNT_W, 32, half-period counter width.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a request.
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_freq  in  32  requested output frequency in Hz.
- cfg_err  out  1  one-cycle pulse: request rejected.
- en  in  CHANNELS  per-channel run enable.
- clk_out  out  CHANNELS  divided clocks, 50 % duty for the computed half-period.
- tick  out  CHANNELS  one-cycle pulse on each 0→1 transition of clk_out.

## Operation
- Reset (rst=0): clk_out=0, tick=0, cfg_err=0, cfg_ready=1, all counters 0, every channel is unconfigured. Takes effect immediately and aborts any division in progress.
- Handshake: a transfer happens on an edge with cfg_valid && cfg_ready. cfg_chan/cfg_freq are captured at that edge. cfg_ready stays low until the result is committed.
- Range check: cfg_freq==0, cfg_freq > CLK_HZ/2, or cfg_chan ≥ CHANNELS means reject. cfg_err pulses for one cycle. No state changes.
- Conversion: half = floor(CLK_HZ / (2·cfg_freq)), computed by a restoring divider. The divisor is 33 bits wide. The quotient is truncated to CNT_W bits. The range check guarantees half ≥ 1.
- Controller FSM:
  - IDLE →(accept, in range) DIV.
  - IDLE →(accept, out of range) ERR.
  - DIV, 32 iterations → COMMIT.
  - COMMIT → IDLE.
  - ERR → IDLE.
- Commit:
  - If the channel is unconfigured or en=0, half is written to both the active and shadow registers, cnt=0, and the channel becomes configured.
  - Otherwise half is written to the shadow register only.
- Channel run (configured, en=1):
  - cnt increments each cycle.
  - At cnt==active−1: cnt←0, clk_out toggles, active←shadow.
  - tick=1 in the cycle after clk_out rises, i.e. tick is registered coincident with the new high level.
- en=0 or unconfigured: cnt←0, clk_out←0, tick=0 on the next edge. The stored configuration is kept.
- Simultaneous toggle and commit on the same channel and the same edge: the toggle loads the old shadow, and the new value lands in shadow for the following toggle.

## Timing
- Accept at edge k.
  - In range: DIV runs edges k+1…k+32, COMMIT at edge k+33, cfg_ready=1 from k+34.
  - Rejected: cfg_err=1 during cycle k+1 to k+2, cfg_ready=1 from k+2.
- A configured channel produces its first rise `active` cycles after commit. The output period is 2·half cycles.
- Rate change latency: at most one half-period after commit.
- Steady state: clk_out and tick are registered outputs with no combinational path from any input.

## Structure
- Package clkdiv_pkg holds:
  - the FSM state enum {IDLE, DIV, COMMIT, ERR};
  - the default CLK_HZ constant;
  - a helper that computes the channel-index width.
- Sub-module serial_divider (32-bit dividend, 33-bit divisor, start/done, one quotient bit per cycle) is instantiated once. The per-channel counters are a generate loop in the top.

## Test plan
- Reset, then write ch0 with freq 25_000_000 and en=1 → cfg_ready low for 33 cycles. clk_out[0] has a period of 4 cycles, 2 high / 2 low. tick[0] pulses every 4 cycles.
- ch1 freq 50_000_000 → half=1, clk_out[1] toggles every cycle. Write freq 30_000_000 → half=1 (floor), same waveform.
- ch0 running at 25 MHz, write freq 10_000_000 → the current half-period finishes at 2 cycles, then half-periods of 5 cycles. No runt pulse.
- freq 0, then freq 60_000_000 → cfg_err pulse for each, cfg_ready back after 2 cycles, ch0 output unchanged.
- Deassert en[0] mid high phase → clk_out[0]=0 next edge. Reassert → resumes from cnt=0 at the last configured rate.
- Assert rst during DIV → all outputs 0 immediately, cfg_ready=1. After release, all channels are unconfigured and held low.
